sr_latch_driver: RTL and testbench

//  Synchronous front-end driving a gated NAND SR latch's S, R and C (enable) inputs.

---
 rtl/sr_latch_driver.sv | 165 ++++++++++++++++
 tb/tb_sr_latch_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sr_latch_driver: sequences S/R setup, C pulse and S/R hold for a gated NAND
// | SR latch. Optional Q readback check enabled by macro SRL_READBACK_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module sr_latch_driver #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 3,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic C,
  output logic busy,
  output logic done,
  output logic drop,
  output logic err
);

  localparam logic [7:0] c_setup_ld = 8'(SETUP_CYC - 1);
  localparam logic [7:0] c_pulse_ld = 8'(PULSE_CYC - 1);
  localparam logic [7:0] c_hold_ld  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_q, dir_d;
  logic       s_q, s_d, r_q, r_d, c_q, c_d;
  logic       busy_q, busy_d, done_q, done_d, drop_q, drop_d, err_q, err_d;

`ifndef SRL_READBACK_EN
  logic w_unused_q_fb;
  assign w_unused_q_fb = q_fb;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    s_d     = 1'b0;
    r_d     = 1'b0;
    c_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (set_req || clr_req) begin
          // Simultaneous requests resolve to clear.
          dir_d   = ~clr_req;
          cnt_d   = c_setup_ld;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = c_pulse_ld;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = c_hold_ld;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
`ifdef SRL_READBACK_EN
          state_d = ST_CHECK;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef SRL_READBACK_EN
      ST_CHECK: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = (q_fb != dir_q);
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      drop_d = set_req | clr_req;
    end

    // Outputs are decoded from the next state so they register in step with it.
    case (state_d)
      ST_SETUP, ST_HOLD: begin
        s_d    = dir_d;
        r_d    = ~dir_d;
        busy_d = 1'b1;
      end
      ST_PULSE: begin
        s_d    = dir_d;
        r_d    = ~dir_d;
        c_d    = 1'b1;
        busy_d = 1'b1;
      end
      ST_CHECK: busy_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      dir_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      s_q     <= s_d;
      r_q     <= r_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign S    = s_q;
  assign R    = r_q;
  assign C    = c_q;
  assign busy = busy_q;
  assign done = done_q;
  assign drop = drop_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_driver.sv
`default_nettype none
// Directed testbench for sr_latch_driver with a behavioural gated SR latch on the outputs.
module tb_sr_latch_driver;

`ifdef SRL_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int DONE_CYC = 7 + RB;

  logic clk = 1'b0;
  logic rst, set_req, clr_req, q_fb;
  logic S, R, C, busy, done, drop, err;
  logic latch_q = 1'b0;
  logic fb_force_en, fb_force_val;
  int   checks = 0;
  int   errors = 0;

  sr_latch_driver dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .clr_req (clr_req),
    .q_fb    (q_fb),
    .S       (S),
    .R       (R),
    .C       (C),
    .busy    (busy),
    .done    (done),
    .drop    (drop),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (C) begin
      if (S && !R) latch_q <= 1'b1;
      else if (R && !S) latch_q <= 1'b0;
    end
  end

  assign q_fb = fb_force_en ? fb_force_val : latch_q;

  always @(negedge clk) begin
    checks++;
    assert (!(S && R)) else begin
      errors++;
      $display("FAIL s_and_r: S=%b R=%b required not both 1 at %0t", S, R, $time);
    end
    checks++;
    assert (!C || (S ^ R)) else begin
      errors++;
      $display("FAIL c_needs_one: C=%b S=%b R=%b required S^R=1 at %0t", C, S, R, $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {S,R,C,busy,done,drop,err} expected k cycles after the request edge.
  function automatic logic [6:0] exp_vec(int k, bit dir, bit drp);
    logic sr_on;
    sr_on = (k >= 1) && (k <= 6);
    return {dir && sr_on, !dir && sr_on, (k >= 3) && (k <= 5), k < DONE_CYC,
            k == DONE_CYC, drp, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b0);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b0);
    end
  endtask

  // Runs one full sequence; drop_at injects set_req so it is seen by the DUT in that cycle.
  task automatic test_sequence(input string name, input bit s_in, input bit c_in,
                               input bit dir, input int drop_at);
    logic [6:0] got, want;
    set_req = s_in;
    clr_req = c_in;
    step();
    set_req = 1'b0;
    clr_req = 1'b0;
    for (int k = 1; k <= DONE_CYC; k++) begin
      got  = {S, R, C, busy, done, drop, err};
      want = exp_vec(k, dir, (drop_at > 0) && (k == drop_at + 1));
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s_cycle%0d: got %b required %b", name, k, got, want);
      end
      set_req = (k == drop_at);
      if (k < DONE_CYC) step();
    end
    set_req = 1'b0;
    step();
    checks++;
    if (latch_q !== dir) begin
      errors++;
      $display("FAIL %s_latch_q: got %b required %b", name, latch_q, dir);
    end
  endtask

  task automatic test_reset_mid();
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b1011000) begin
      errors++;
      $display("FAIL midreset_c_high: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b1011000);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_abort: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b0);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_idle: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b0);
    end
  endtask

  task automatic test_back_to_back();
    int waited;
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    for (int k = 1; k < DONE_CYC; k++) step();
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: got busy/done %b required %b", {busy, done}, 2'b01);
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b0101000) begin
      errors++;
      $display("FAIL b2b_accept: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b0101000);
    end
    waited = 1;
    while (!done && waited < 40) begin
      step();
      waited++;
    end
    checks++;
    if (waited !== DONE_CYC) begin
      errors++;
      $display("FAIL b2b_second_done: done after %0d cycles required %0d", waited, DONE_CYC);
    end
    step();
  endtask

`ifdef SRL_READBACK_EN
  task automatic test_readback(input bit fb_val, input bit exp_err);
    fb_force_en  = 1'b1;
    fb_force_val = fb_val;
    set_req = 1'b1;
    step();
    set_req = 1'b0;
    for (int k = 1; k < 7; k++) step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== 7'b0001000) begin
      errors++;
      $display("FAIL rb_check_state: got %b required %b", {S, R, C, busy, done, drop, err}, 7'b0001000);
    end
    step();
    checks++;
    if ({S, R, C, busy, done, drop, err} !== {6'b000010, exp_err}) begin
      errors++;
      $display("FAIL rb_done_fb%0d: got %b required %b", fb_val, {S, R, C, busy, done, drop, err},
               {6'b000010, exp_err});
    end
    fb_force_en = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    fb_force_en = 1'b0;
    fb_force_val = 1'b0;
    test_reset();
    test_sequence("set", 1'b1, 1'b0, 1'b1, 0);
    test_sequence("clear", 1'b0, 1'b1, 1'b0, 0);
    test_sequence("set_again", 1'b1, 1'b0, 1'b1, 0);
    test_sequence("both", 1'b1, 1'b1, 1'b0, 0);
    test_sequence("drop", 1'b0, 1'b1, 1'b0, 4);
    test_reset_mid();
    test_sequence("after_reset", 1'b0, 1'b1, 1'b0, 0);
    test_back_to_back();
`ifdef SRL_READBACK_EN
    test_readback(1'b0, 1'b1);
    test_readback(1'b1, 1'b0);
`endif
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
